// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-counter with load, dual count enables and ripple borrow.
// RELOAD_MODE = 0 stops at 00 and holds done high; RELOAD_MODE = 1 reloads the
// last loaded value on the 01 -> reload step and pulses done for one cycle.
// Optional macro BCD_DOWN_TIMER_ERR_EN adds an err output; when it is defined,
// illegal load digits are clamped to 9.
//
// state | meaning
// IDLE  | after reset, waiting for the first load; enables ignored
// RUN   | counting down when enp and ent are both high
// DONE  | terminal count reached (or 00 loaded); q_out holds, done high
module bcd_down_timer #(
  parameter int RELOAD_MODE = 0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ldn,
  input  logic       enp,
  input  logic       ent,
  input  logic [7:0] data_in,
  output logic [7:0] q_out,
  output logic       rbo,
  output logic       done,
  output logic       busy
`ifdef BCD_DOWN_TIMER_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bit RELOAD = (RELOAD_MODE != 0);

  state_t     state_r, state_nxt;
  logic [7:0] q_r, q_nxt;
  logic [7:0] rel_r, rel_nxt;
  logic       done_r, done_nxt;
  logic [7:0] ld_val;
  logic       count_ok;

`ifdef BCD_DOWN_TIMER_ERR_EN
  logic       err_r, err_nxt;
  logic       ld_illegal;
`endif

  // Illegal digits decrement in plain binary until they drop to 9 or below,
  // which is exactly what 4-bit subtraction per digit gives.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) r = {v[7:4], v[3:0] - 4'd1};
    else                r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  // Value a load would take; with the error option each digit is clamped to 9.
  always_comb begin
`ifdef BCD_DOWN_TIMER_ERR_EN
    ld_val[7:4] = (data_in[7:4] > 4'd9) ? 4'd9 : data_in[7:4];
    ld_val[3:0] = (data_in[3:0] > 4'd9) ? 4'd9 : data_in[3:0];
    ld_illegal  = (data_in[7:4] > 4'd9) || (data_in[3:0] > 4'd9);
`else
    ld_val = data_in;
`endif
  end

  // Next-state logic: load beats count beats hold.
  always_comb begin
    state_nxt = state_r;
    q_nxt     = q_r;
    rel_nxt   = rel_r;
    done_nxt  = done_r;
`ifdef BCD_DOWN_TIMER_ERR_EN
    err_nxt   = err_r;
`endif
    count_ok  = (state_r == RUN) && enp && ent;

    if (!ldn) begin
      q_nxt     = ld_val;
      rel_nxt   = ld_val;
      state_nxt = (ld_val == 8'h00) ? DONE : RUN;
      done_nxt  = (ld_val == 8'h00);
`ifdef BCD_DOWN_TIMER_ERR_EN
      err_nxt   = ld_illegal;
`endif
    end else if (count_ok) begin
      if (q_r == 8'h01) begin
        done_nxt = 1'b1;
        if (RELOAD) begin
          q_nxt = rel_r;
        end else begin
          q_nxt     = 8'h00;
          state_nxt = DONE;
        end
      end else begin
        q_nxt    = bcd_dec(q_r);
        done_nxt = 1'b0;
      end
    end else if (RELOAD && (state_r == RUN)) begin
      // a reload pulse lasts one cycle even when counting is paused
      done_nxt = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= IDLE;
      q_r     <= 8'h00;
      rel_r   <= 8'h00;
      done_r  <= 1'b0;
`ifdef BCD_DOWN_TIMER_ERR_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      q_r     <= q_nxt;
      rel_r   <= rel_nxt;
      done_r  <= done_nxt;
`ifdef BCD_DOWN_TIMER_ERR_EN
      err_r   <= err_nxt;
`endif
    end
  end

  assign q_out = q_r;
  assign done  = done_r;
  assign busy  = (state_r == RUN);
  assign rbo   = (q_r == 8'h00) && ent;
`ifdef BCD_DOWN_TIMER_ERR_EN
  assign err   = err_r;
`endif

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: one instance per RELOAD_MODE, driven
// with identical stimulus. The driver pushes the reference model's expected
// post-edge outputs; a monitor pops and compares after every rising edge.
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ldn = 1'b1;
  logic       enp = 1'b0;
  logic       ent = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] q0, q1;
  logic       rbo0, rbo1, done0, done1, busy0, busy1;
`ifdef BCD_DOWN_TIMER_ERR_EN
  logic       err0, err1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.RELOAD_MODE(0)) dut0 (
    .clk(clk), .clrn(clrn), .ldn(ldn), .enp(enp), .ent(ent), .data_in(data_in),
    .q_out(q0), .rbo(rbo0), .done(done0), .busy(busy0)
`ifdef BCD_DOWN_TIMER_ERR_EN
    , .err(err0)
`endif
  );

  bcd_down_timer #(.RELOAD_MODE(1)) dut1 (
    .clk(clk), .clrn(clrn), .ldn(ldn), .enp(enp), .ent(ent), .data_in(data_in),
    .q_out(q1), .rbo(rbo1), .done(done1), .busy(busy1)
`ifdef BCD_DOWN_TIMER_ERR_EN
    , .err(err1)
`endif
  );

  // Reference model: digits, reload value, mode (0 idle, 1 running, 2 finished).
  typedef struct {
    logic [7:0] q;
    logic       done;
    logic       busy;
    logic       err;
  } exp_t;

  logic [3:0] m_tens [2];
  logic [3:0] m_ones [2];
  logic [7:0] m_rel  [2];
  int         m_st   [2];
  logic       m_done [2];
  logic       m_err  [2];

  exp_t sb_q [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_tens[m] = 4'd0; m_ones[m] = 4'd0; m_rel[m] = 8'h00;
      m_st[m] = 0; m_done[m] = 1'b0; m_err[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input bit l, input bit e_p, input bit e_t,
                            input logic [7:0] d);
    logic [3:0] t, o;
    if (l) begin
      t = d[7:4]; o = d[3:0];
`ifdef BCD_DOWN_TIMER_ERR_EN
      m_err[m] = (t > 9) || (o > 9);
      if (t > 9) t = 4'd9;
      if (o > 9) o = 4'd9;
`endif
      m_tens[m] = t; m_ones[m] = o; m_rel[m] = {t, o};
      m_st[m]   = ({t, o} == 8'h00) ? 2 : 1;
      m_done[m] = ({t, o} == 8'h00);
    end else if (m_st[m] == 1 && e_p && e_t) begin
      if (m_tens[m] == 0 && m_ones[m] == 1) begin
        m_done[m] = 1'b1;
        if (m == 0) begin
          m_ones[m] = 4'd0; m_st[m] = 2;
        end else begin
          m_tens[m] = m_rel[m][7:4]; m_ones[m] = m_rel[m][3:0];
        end
      end else begin
        m_done[m] = 1'b0;
        if (m_ones[m] != 0) m_ones[m] = m_ones[m] - 4'd1;
        else begin m_ones[m] = 4'd9; m_tens[m] = m_tens[m] - 4'd1; end
      end
    end else if (m == 1 && m_st[m] == 1) begin
      m_done[m] = 1'b0;
    end
  endtask

  function automatic exp_t model_out(input int m);
    exp_t e;
    e.q = {m_tens[m], m_ones[m]};
    e.done = m_done[m];
    e.busy = (m_st[m] == 1);
    e.err = m_err[m];
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, check async/comb outputs,
  // then queue what both instances must show after the next rising edge.
  task automatic drive_cycle(input bit rst, input bit l, input bit e_p, input bit e_t,
                             input logic [7:0] d);
    @(negedge clk);
    ldn = ~l; enp = e_p; ent = e_t; data_in = d;
    clrn = ~rst;
    #1;
    if (rst) begin
      model_reset();
      check("rst_q0", q0, 8'h00);
      check("rst_q1", q1, 8'h00);
      check("rst_done0", {7'd0, done0}, 8'h00);
      check("rst_done1", {7'd0, done1}, 8'h00);
      check("rst_busy0", {7'd0, busy0}, 8'h00);
      check("rst_busy1", {7'd0, busy1}, 8'h00);
    end
    check("rbo0", {7'd0, rbo0}, {7'd0, (model_out(0).q == 8'h00) && e_t});
    check("rbo1", {7'd0, rbo1}, {7'd0, (model_out(1).q == 8'h00) && e_t});
    if (!rst) begin
      model_step(0, l, e_p, e_t, d);
      model_step(1, l, e_p, e_t, d);
    end
    sb_q.push_back(model_out(0));
    sb_q.push_back(model_out(1));
  endtask

  // Monitor: after every rising edge compare the DUTs against queued results.
  initial begin
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() >= 2) begin
        e0 = sb_q.pop_front();
        e1 = sb_q.pop_front();
        check("q_m0", q0, e0.q);
        check("done_m0", {7'd0, done0}, {7'd0, e0.done});
        check("busy_m0", {7'd0, busy0}, {7'd0, e0.busy});
        check("q_m1", q1, e1.q);
        check("done_m1", {7'd0, done1}, {7'd0, e1.done});
        check("busy_m1", {7'd0, busy1}, {7'd0, e1.busy});
`ifdef BCD_DOWN_TIMER_ERR_EN
        check("err_m0", {7'd0, err0}, {7'd0, e0.err});
        check("err_m1", {7'd0, err1}, {7'd0, e1.err});
`endif
      end
    end
  end

  initial begin
    logic [7:0] d;
    int r;
    model_reset();
    drive_cycle(1, 0, 1, 1, 8'h00);
    drive_cycle(1, 0, 1, 0, 8'h00);
    // idle: enables ignored without a load
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 1, 1, 8'h00);
    // count down from 12 to the terminal value and beyond
    drive_cycle(0, 1, 1, 1, 8'h12);
    for (int i = 0; i < 15; i++) drive_cycle(0, 0, 1, 1, 8'h00);
    // short reload loop
    drive_cycle(0, 1, 1, 1, 8'h03);
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 1, 1, 8'h00);
    // load vs count on the same edge, pause with ent low, load of 00
    drive_cycle(0, 1, 1, 1, 8'h21);
    drive_cycle(0, 0, 1, 1, 8'h00);
    drive_cycle(0, 1, 1, 1, 8'h45);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 0, 8'h00);
    drive_cycle(0, 0, 0, 1, 8'h00);
    drive_cycle(0, 1, 1, 1, 8'h00);
    drive_cycle(0, 0, 1, 1, 8'h00);
    // reset in the middle of a count
    drive_cycle(0, 1, 1, 1, 8'h37);
    drive_cycle(0, 0, 1, 1, 8'h00);
    drive_cycle(1, 0, 1, 1, 8'h00);
    drive_cycle(1, 1, 1, 0, 8'h55);
    drive_cycle(0, 0, 1, 1, 8'h00);
    // illegal digits
    drive_cycle(0, 1, 1, 1, 8'hA7);
    drive_cycle(0, 0, 1, 1, 8'h00);
    drive_cycle(0, 1, 1, 1, 8'h15);
    drive_cycle(0, 1, 1, 1, 8'h0C);
    for (int i = 0; i < 16; i++) drive_cycle(0, 0, 1, 1, 8'h00);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      if (r < 2) begin
        int v;
        v = $urandom_range(0, 99);
        d = 8'((v / 10) * 16 + (v % 10));
      end else if (r == 2) d = 8'($urandom_range(0, 3));
      else d = 8'($urandom);
      drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, d);
    end
    drive_cycle(0, 0, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    check("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL have parameter RELOAD_MODE, default 0; 0 = stop at 00, 1 = auto-reload the last loaded value and keep running.
REQ-002 The block SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-003 The block SHALL have port clrn, input, 1 bit; asynchronous active-low reset.
REQ-004 The block SHALL have port ldn, input, 1 bit; synchronous active-low load.
REQ-005 The block SHALL have port enp, input, 1 bit; parallel count enable.
REQ-006 The block SHALL have port ent, input, 1 bit; trickle count enable, which also gates rbo.
REQ-007 The block SHALL have port data_in, input, 8 bits; load value as 2 BCD digits, [7:4] tens, [3:0] ones.
REQ-008 The block SHALL have port q_out, output, 8 bits; current count as 2 BCD digits.
REQ-009 The block SHALL have port rbo, output, 1 bit; ripple borrow out for cascading.
REQ-010 The block SHALL have port done, output, 1 bit; terminal-count indication.
REQ-011 The block SHALL have port busy, output, 1 bit; high while in RUN.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE; busy SHALL equal (state==RUN).
REQ-013 Each clk edge SHALL apply this priority: load, then count, then hold.
REQ-014 Load (ldn=0), in any state: q_out and the internal reload register SHALL both take data_in; next state SHALL be RUN if data_in!=8'h00, else DONE.
REQ-015 Count SHALL occur only in RUN with enp=1 and ent=1; in IDLE and DONE, enp and ent SHALL be ignored and q_out SHALL hold.
REQ-016 BCD decrement: if ones!=0, ones-1; if ones==0, ones becomes 9 and tens-1.
REQ-017 With RELOAD_MODE=0, a count from q_out=8'h01 SHALL set q_out to 8'h00 and enter DONE.
REQ-018 With RELOAD_MODE=0, done SHALL be a registered level, high exactly while in DONE.
REQ-019 With RELOAD_MODE=1, a count from q_out=8'h01 SHALL set q_out to the reload register value and stay in RUN, with no 00 cycle.
REQ-020 With RELOAD_MODE=1, done SHALL be a one-cycle registered pulse, asserted on the cycle after each reload event.
REQ-021 With RELOAD_MODE=1, a load of 8'h00 SHALL still enter DONE, and done SHALL be level-high while in DONE.
REQ-022 rbo SHALL be combinational, equal to (q_out==8'h00) && ent, independent of enp and state.
REQ-023 When ldn=0 and a count condition occur on the same edge, the load SHALL win.
REQ-024 With enp=0 or ent=0 in RUN, q_out, state and done SHALL hold (in RELOAD_MODE=1, a done pulse SHALL still drop after one cycle).

Reset
REQ-025 clrn=0 SHALL immediately, without a clock edge, set q_out=8'h00, reload register=8'h00, state=IDLE, done=0 and busy=0.
REQ-026 Reset SHALL override a load or count in progress.
REQ-027 After clrn is released, the block SHALL remain in IDLE until the first load.
REQ-028 rbo SHALL follow ent during reset, because q_out is 8'h00.

Configuration
REQ-029 Macro BCD_DOWN_TIMER_ERR_EN defined: the block SHALL add output port err, 1 bit.
REQ-030 With the macro defined, a load whose data_in digit is >9 SHALL clamp that digit to 9 in both q_out and the reload register, and set err=1.
REQ-031 With the macro defined, err SHALL clear on the next load with legal digits or on reset.
REQ-032 Macro not defined: the block SHALL have no err port and SHALL load digits unchanged.
REQ-033 Macro not defined: an illegal digit (>9) SHALL decrement in binary until it is ≤9, then follow normal BCD rules.

Verification
REQ-034 Reset: clrn=0 mid-count from 8'h37 -> q_out=8'h00, state=IDLE, done=0, busy=0 with no clock edge; rbo=ent.
REQ-035 IDLE ignore: reset released, enp=ent=1 for 10 cycles, no load -> q_out stays 8'h00, busy=0.
REQ-036 RELOAD_MODE=0 count: load 8'h12, enp=ent=1 -> q_out sequence 12,11,10,09,...,01,00; done rises after 12 counts; q_out holds 00 and rbo=1.
REQ-037 RELOAD_MODE=1 reload: load 8'h03, enp=ent=1 -> 03,02,01,03,02,...; done pulses one cycle after each 01->03; 8'h00 never appears.
REQ-038 Simultaneous events: in RUN at 8'h20, ldn=0 with data_in=8'h45 and enp=ent=1 -> q_out=8'h45; ent=0 -> q_out holds and rbo=0; load 8'h00 -> DONE, done=1.
REQ-039 Macro defined: load 8'hA7 -> q_out=8'h97, err=1; then load 8'h15 -> err=0.
